// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one external memory port between the instruction fetch
//            unit (32-bit fetch as two 16-bit read beats) and the CPU data
//            path (16-bit load/store). Data has fixed priority, fetches are
//            atomic, and every request receives exactly one ack pulse.
// Ports    : clk, rst (sync, active-low)
//            Fetch  : f_req, f_addr[15:0] -> f_instr[31:0], f_ack
//            Data   : d_req, d_we, d_addr[15:0], d_wdata[15:0]
//                     -> d_rdata[15:0], d_ack
//            Status : err (high with the ack of a timed-out access)
//            Memory : mem_addr, mem_wdata, mem_rd, mem_wr (to memory)
//                     mem_rdata, mem_busy, mem_ready (from memory)
// Options  : MEM_ARB_TIMEOUT_EN - when defined, each wait state gives up
//            after TIMEOUT cycles without mem_ready and acks with err=1.
//            When undefined, waits are unbounded and err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic [31:0] f_instr,
    output logic        f_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        D_ISSUE  = 3'd1,
        D_WAIT   = 3'd2,
        F_ISSUE0 = 3'd3,
        F_WAIT0  = 3'd4,
        F_ISSUE1 = 3'd5,
        F_WAIT1  = 3'd6,
        DONE     = 3'd7
    } state_t;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        data_own_q, data_own_d;   // 1: data port owns the transaction
    logic        we_q, we_d;               // store flag latched at grant
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic [31:0] f_instr_q, f_instr_d;
    logic        w_timeout;                // current wait beat is abandoned

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
    logic       w_in_wait;

    assign w_in_wait  = (state_q == D_WAIT) || (state_q == F_WAIT0) ||
                        (state_q == F_WAIT1);
    assign w_timeout  = w_in_wait && !mem_ready && (wait_cnt_q == c_timeout_last);

    // Counter is zero whenever not waiting, so every wait state starts at 0.
    always_comb begin
        wait_cnt_d = 8'd0;
        if (w_in_wait && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        // A timeout always moves to DONE, so err_q lines up with the ack.
        err_d = w_timeout;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
    assign w_unused_timeout = ^c_timeout_last;
`endif

    always_comb begin
        state_d     = state_q;
        data_own_d  = data_own_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_rdata_d   = d_rdata_q;
        f_instr_d   = f_instr_q;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        f_ack       = 1'b0;
        d_ack       = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d    = D_ISSUE;
                    data_own_d = 1'b1;
                    we_d       = d_we;
                    mem_addr_d = d_addr;
                    if (d_we) begin
                        mem_wdata_d = d_wdata;
                    end
                end else if (f_req) begin
                    state_d    = F_ISSUE0;
                    data_own_d = 1'b0;
                    we_d       = 1'b0;
                    mem_addr_d = f_addr;
                end
            end
            D_ISSUE: begin
                if (!mem_busy) begin
                    mem_wr  = we_q;
                    mem_rd  = !we_q;
                    state_d = D_WAIT;
                end
            end
            D_WAIT: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (w_timeout) begin
                    if (!we_q) begin
                        d_rdata_d = 16'h0000;
                    end
                    state_d = DONE;
                end
            end
            F_ISSUE0: begin
                if (!mem_busy) begin
                    mem_rd  = 1'b1;
                    state_d = F_WAIT0;
                end
            end
            F_WAIT0: begin
                if (mem_ready) begin
                    f_instr_d[15:0] = mem_rdata;
                    mem_addr_d      = f_addr + 16'd1;   // wraps 0xFFFF -> 0x0000
                    state_d         = F_ISSUE1;
                end else if (w_timeout) begin
                    // Second beat is skipped, so neither half holds valid data.
                    f_instr_d = 32'h0000_0000;
                    state_d   = DONE;
                end
            end
            F_ISSUE1: begin
                if (!mem_busy) begin
                    mem_rd  = 1'b1;
                    state_d = F_WAIT1;
                end
            end
            F_WAIT1: begin
                if (mem_ready) begin
                    f_instr_d[31:16] = mem_rdata;
                    state_d          = DONE;
                end else if (w_timeout) begin
                    f_instr_d[31:16] = 16'h0000;
                    state_d          = DONE;
                end
            end
            DONE: begin
                d_ack   = data_own_q;
                f_ack   = !data_own_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            data_own_q  <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            d_rdata_q   <= 16'h0000;
            f_instr_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            data_own_q  <= data_own_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_rdata_q   <= d_rdata_d;
            f_instr_q   <= f_instr_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_instr   = f_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Requesters push expected
//            responses into per-port queues; a monitor pops and compares on
//            every ack. A behavioural memory answers strobes, and a reference
//            memory predicts load/fetch data from the request order per port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic [31:0] f_instr;
    logic        f_ack, d_ack, err;
    logic [15:0] d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_busy, mem_ready;

    mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_instr(f_instr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [31:0] data;
        bit          err;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        bit          wr;
        logic [15:0] wdata;
    } strobe_t;

    exp_t        exp_d[$];
    exp_t        exp_f[$];
    logic [15:0] dev_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_last = 16'h0000;     // d_rdata a store must leave alone

    int      n_checks = 0;
    int      n_fail   = 0;
    int      dev_mode = 0;   // 0 fast, 1 random, 2 never ready
    int      busy_from = 0, busy_until = 0;
    int      kick_req = 0;
    int      strobe_count = 0, last_strobe_cyc = 0;
    int      f_ack_count = 0, d_ack_count = 0;
    strobe_t sh0, sh1;       // previous and latest strobe

    function automatic logic [15:0] dflt(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'h9E37;
        return t ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] dev_read(input logic [15:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic issue_data(input bit we, input logic [15:0] a, input logic [15:0] wd,
                              input bit exp_err);
        exp_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.err = exp_err;
        if (exp_err) begin
            if (!we) ref_last = 16'h0000;
        end else if (we) begin
            ref_mem[a] = wd;
        end else begin
            ref_last = ref_read(a);
        end
        e.data = {16'h0000, ref_last};
        exp_d.push_back(e);
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    endtask

    task automatic issue_fetch(input logic [15:0] a);
        exp_t        e;
        logic [15:0] a1;
        a1 = a + 16'd1;
        e.we = 1'b0; e.addr = a; e.wdata = 16'h0; e.err = 1'b0;
        e.data = {ref_read(a1), ref_read(a)};
        exp_f.push_back(e);
        f_addr = a; f_req = 1'b1;
    endtask

    task automatic wait_ack(input bit is_data, output int ack_cyc);
        bit seen;
        seen = 1'b0;
        ack_cyc = -1;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if ((is_data && d_ack) || (!is_data && f_ack)) begin
                seen = 1'b1;
                ack_cyc = cyc;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: no %s ack within 300 cycles", is_data ? "data" : "fetch");
        end
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: no memory strobe within 300 cycles");
        end
    endtask

    // Behavioural memory: drives inputs #1 after the edge, samples strobes
    // on the falling edge and answers with mem_ready after a chosen delay.
    initial begin : device
        bit          pend;
        int          lat;
        int          kick_seen;
        logic [15:0] rd_val;
        pend = 1'b0; lat = 0; kick_seen = 0; rd_val = 16'h0;
        mem_busy = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (kick_req != kick_seen) begin
                kick_seen = kick_req;
                mem_ready = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (pend) begin
                if (lat == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_val;
                    pend = 1'b0;
                end else begin
                    lat--;
                end
            end else if (dev_mode == 1 && $urandom_range(0, 9) == 0) begin
                mem_ready = 1'b1;            // stray pulse, must be ignored
                mem_rdata = 16'($urandom);
            end
            if (dev_mode == 1) mem_busy = ($urandom_range(0, 3) == 0);
            else               mem_busy = (cyc >= busy_from) && (cyc < busy_until);
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else if (mem_rd || mem_wr) begin
                if (mem_wr) dev_mem[mem_addr] = mem_wdata;
                else        rd_val = dev_read(mem_addr);
                if (dev_mode != 2) begin
                    pend = 1'b1;
                    lat  = (dev_mode == 1) ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        exp_t        e;
        logic [15:0] a1;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_busy) chk("no_strobe_while_busy", 32'(mem_rd | mem_wr), 32'd0);
                if (mem_rd || mem_wr) begin
                    chk("single_strobe", 32'(mem_rd & mem_wr), 32'd0);
                    sh0 = sh1;
                    sh1.addr = mem_addr; sh1.wr = mem_wr; sh1.wdata = mem_wdata;
                    strobe_count++;
                    last_strobe_cyc = cyc;
                end
                if (f_ack || d_ack) begin
                    chk("ack_exclusive", 32'((f_ack & d_ack) | mem_rd | mem_wr), 32'd0);
                end
                if (d_ack) begin
                    d_ack_count++;
                    if (exp_d.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_d_ack: d_ack with no request outstanding (cycle %0d)", cyc);
                    end else begin
                        e = exp_d.pop_front();
                        chk("d_rdata", 32'(d_rdata), e.data);
                        chk("d_err", 32'(err), 32'(e.err));
                        chk("d_strobe_addr", 32'(sh1.addr), 32'(e.addr));
                        chk("d_strobe_kind", 32'(sh1.wr), 32'(e.we));
                        chk("d_mem_addr_held", 32'(mem_addr), 32'(e.addr));
                        if (e.we) chk("d_mem_wdata", 32'(sh1.wdata), 32'(e.wdata));
                    end
                end
                if (f_ack) begin
                    f_ack_count++;
                    if (exp_f.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_f_ack: f_ack with no request outstanding (cycle %0d)", cyc);
                    end else begin
                        e  = exp_f.pop_front();
                        a1 = e.addr + 16'd1;
                        chk("f_instr", f_instr, e.data);
                        chk("f_err", 32'(err), 32'(e.err));
                        chk("f_beat0_addr", 32'({sh0.wr, sh0.addr}), 32'({1'b0, e.addr}));
                        chk("f_beat1_addr", 32'({sh1.wr, sh1.addr}), 32'({1'b0, a1}));
                        chk("f_mem_addr_held", 32'(mem_addr), 32'(a1));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c, ac, base, base2;
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        sh0 = '{16'h0, 1'b0, 16'h0}; sh1 = '{16'h0, 1'b0, 16'h0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_f_ack", 32'(f_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_f_instr", f_instr, 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // Load with ready one cycle after the strobe
        dev_mem[16'h1234] = 16'hBEEF; ref_mem[16'h1234] = 16'hBEEF;
        @(posedge clk); #1; c = cyc;
        issue_data(1'b0, 16'h1234, 16'h0, 1'b0);
        wait_ack(1'b1, ac);
        chk("load_latency", 32'(ac - c), 32'd3);
        chk("load_strobe_cycle", 32'(last_strobe_cyc - c), 32'd1);
        chk("load_d_rdata_beef", 32'(d_rdata), 32'h0000BEEF);
        @(posedge clk); #1; d_req = 1'b0;

        // Fetch with address wrap
        dev_mem[16'hFFFF] = 16'h1111; ref_mem[16'hFFFF] = 16'h1111;
        dev_mem[16'h0000] = 16'h2222; ref_mem[16'h0000] = 16'h2222;
        @(posedge clk); #1; c = cyc;
        issue_fetch(16'hFFFF);
        wait_ack(1'b0, ac);
        chk("fetch_latency", 32'(ac - c), 32'd5);
        chk("fetch_wrap_instr", f_instr, 32'h22221111);
        @(posedge clk); #1; f_req = 1'b0;

        // Priority and fetch atomicity
        @(posedge clk); #1;
        base = f_ack_count;
        issue_fetch(16'h0300);
        issue_data(1'b0, 16'h0200, 16'h0, 1'b0);
        wait_ack(1'b1, ac);
        #1 chk("data_before_fetch", 32'(f_ack_count - base), 32'd0);
        @(posedge clk); #1; d_req = 1'b0;
        wait_strobe();
        @(posedge clk); #1;
        base2 = d_ack_count;
        issue_data(1'b1, 16'h4005, 16'h1357, 1'b0);
        wait_ack(1'b0, ac);
        #1 chk("fetch_atomic", 32'(d_ack_count - base2), 32'd0);
        @(posedge clk); #1; f_req = 1'b0;
        wait_ack(1'b1, ac);
        @(posedge clk); #1; d_req = 1'b0;

        // Store with the memory busy for four cycles
        @(posedge clk); #1; c = cyc;
        base = strobe_count;
        busy_from = c + 1; busy_until = c + 5;
        issue_data(1'b1, 16'h4001, 16'h00A5, 1'b0);
        wait_ack(1'b1, ac);
        chk("busy_strobe_cycle", 32'(last_strobe_cyc - c), 32'd5);
        chk("busy_single_strobe", 32'(strobe_count - base), 32'd1);
        chk("busy_ack_latency", 32'(ac - c), 32'd7);
        @(posedge clk); #1; d_req = 1'b0;

        // Reset in the middle of a fetch
        dev_mode = 2;
        @(posedge clk); #1;
        issue_fetch(16'h0100);
        wait_strobe();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1; f_req = 1'b0;
        exp_f.delete();
        ref_last = 16'h0000;
        base = f_ack_count + d_ack_count;
        kick_req++;
        repeat (6) @(negedge clk);
        chk("no_ack_after_reset", 32'(f_ack_count + d_ack_count - base), 32'd0);
        chk("post_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("post_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("post_rst_f_instr", f_instr, 32'd0);
        chk("post_rst_d_rdata", 32'(d_rdata), 32'd0);
        dev_mode = 0;
        @(posedge clk); #1; c = cyc;
        issue_data(1'b0, 16'h4001, 16'h0, 1'b0);
        wait_ack(1'b1, ac);
        chk("post_rst_load_latency", 32'(ac - c), 32'd3);
        @(posedge clk); #1; d_req = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Load that never gets mem_ready
        dev_mode = 2;
        @(posedge clk); #1; c = cyc;
        issue_data(1'b0, 16'h0077, 16'h0, 1'b1);
        wait_ack(1'b1, ac);
        chk("timeout_latency", 32'(ac - c), 32'd10);
        chk("timeout_err", 32'(err), 32'd1);
        @(posedge clk); #1; d_req = 1'b0;
        dev_mode = 0;
`endif

        // Randomized traffic on both ports
        dev_mode = 1;
        fork
            begin : data_port
                int          ack_c;
                bit          we;
                logic [15:0] a;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk); #1;
                    we = 1'($urandom_range(0, 1));
                    if (we || $urandom_range(0, 1) == 1) a = 16'h4000 + 16'($urandom_range(0, 15));
                    else a = 16'($urandom);
                    issue_data(we, a, 16'($urandom), 1'b0);
                    wait_ack(1'b1, ack_c);
                    @(posedge clk); #1; d_req = 1'b0;
                end
            end
            begin : fetch_port
                int          ack_c;
                logic [15:0] a;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk); #1;
                    a = 16'($urandom);
                    // Keep fetches away from the store window so the two
                    // ports never race on the same word.
                    if (a >= 16'h3FF0 && a <= 16'h401F) a = a ^ 16'h8000;
                    issue_fetch(a);
                    wait_ack(1'b0, ack_c);
                    @(posedge clk); #1; f_req = 1'b0;
                end
            end
        join

        repeat (10) @(negedge clk);
        chk("data_queue_drained", 32'(exp_d.size()), 32'd0);
        chk("fetch_queue_drained", 32'(exp_f.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single external memory port between the instruction fetch unit (32-bit fetch as two 16-bit beats) and the CPU data path (16-bit load/store). It sits between the core and the external memory controller, replacing the direct OR of fetch and data read strobes. It sequences every access through the memory's busy/ready handshake and returns one acknowledged response per request.

## Interface
- `TIMEOUT`, default 255: wait-state cycle limit, used only with the timeout feature.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `f_req` in 1: fetch request, held high until `f_ack`.
- `f_addr` in 16: fetch word address; held stable while `f_req` is high.
- `f_instr` out 32: fetched instruction; `[15:0]` from `f_addr`, `[31:16]` from `f_addr+1`; valid when `f_ack` is high.
- `f_ack` out 1: one-cycle completion pulse for the fetch port.
- `d_req` in 1: data request, held high until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load; held stable with `d_req`.
- `d_addr` in 16: data address; held stable with `d_req`.
- `d_wdata` in 16: store data; held stable with `d_req`.
- `d_rdata` out 16: load result; valid when `d_ack` is high.
- `d_ack` out 1: one-cycle completion pulse for the data port.
- `err` out 1: high with an ack when the access timed out; 0 otherwise.
- `mem_addr` out 16: registered memory address.
- `mem_wdata` out 16: registered store data.
- `mem_rd` out 1: one-cycle read strobe.
- `mem_wr` out 1: one-cycle write strobe.
- `mem_rdata` in 16: memory read data; valid with `mem_ready`.
- `mem_busy` in 1: memory cannot accept a strobe this cycle.
- `mem_ready` in 1: one-cycle completion pulse for the outstanding access.

## Operation
- States: IDLE, D_ISSUE, D_WAIT, F_ISSUE0, F_WAIT0, F_ISSUE1, F_WAIT1, DONE.
- IDLE: requests are sampled only in this state. Data has fixed priority over fetch.
  - `d_req` goes to D_ISSUE.
  - Otherwise `f_req` goes to F_ISSUE0.
  - The chosen address, and for stores the data, are latched into `mem_addr`/`mem_wdata`.
- Fetch transactions are atomic: no data request is taken between beat 0 and beat 1.
- *_ISSUE states:
  - While `mem_busy` is high, stay in the state with no strobe.
  - When `mem_busy` is low, assert exactly one of `mem_rd`/`mem_wr` for that cycle and move to the matching *_WAIT.
  - Fetch always uses `mem_rd`. Data uses `mem_wr` if `d_we` is 1, else `mem_rd`.
- *_WAIT states: on `mem_ready`:
  - D_WAIT: capture `mem_rdata` into `d_rdata` (loads only; stores leave it unchanged), go to DONE.
  - F_WAIT0: capture into `f_instr[15:0]`, set `mem_addr <= f_addr + 1` (mod 2^16, so 0xFFFF wraps to 0x0000), go to F_ISSUE1.
  - F_WAIT1: capture into `f_instr[31:16]`, go to DONE.
- `mem_ready` seen in IDLE, *_ISSUE or DONE is ignored.
- DONE: assert `f_ack` or `d_ack` (whichever port owns the transaction) for exactly one cycle, then go to IDLE.
- The requester must drop its `req` in the cycle after its ack, so IDLE sees it low.
- `mem_rd`, `mem_wr`, `f_ack`, `d_ack` and `err` are never high simultaneously with each other, except ack with `err`.

## Timing
- Reset (`rst`=0 at an edge): state IDLE. `mem_rd`, `mem_wr`, `f_ack`, `d_ack` and `err` are 0. `mem_addr`, `mem_wdata`, `d_rdata` and `f_instr` are 0x0000/0x00000000.
- Reset mid-transaction aborts it with no ack. A later `mem_ready` is ignored.
- Strobe timing: `d_req` high in IDLE at edge n, with memory not busy:
  - `mem_rd`/`mem_wr` is high in cycle n+1.
  - `mem_ready` at edge m gives `d_ack` in cycle m+1.
- Minimum data latency with ready one cycle after the strobe: 3 cycles from req sample to ack.
- Minimum fetch latency: 5 cycles.
- At least one IDLE cycle separates consecutive transactions.
- `mem_addr` and `mem_wdata` are stable from the strobe cycle until the transaction ends.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to each *_WAIT and increments each cycle without `mem_ready`.
  - When it reaches `TIMEOUT`, go to DONE with `err`=1 in the ack cycle.
  - The response data of the aborted beat is 0x0000. A timed-out fetch skips its remaining beat.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter; *_WAIT states wait indefinitely.
  - `err` is tied to 0.

## Test plan
- Load: `d_req`=1, `d_we`=0, `d_addr`=0x1234; `mem_ready` one cycle after `mem_rd` with `mem_rdata`=0xBEEF -> `mem_addr`=0x1234, `d_ack` pulses once with `d_rdata`=0xBEEF, 3 cycles after the req sample.
- Fetch with wrap: `f_addr`=0xFFFF; memory returns 0x1111 then 0x2222 -> beat addresses are 0xFFFF then 0x0000, and `f_ack` comes with `f_instr`=0x22221111.
- Priority and atomicity: `f_req` and `d_req` both high in IDLE -> data is served first. Then raise `d_req` again during fetch beat 0 -> both fetch beats complete before the next data strobe.
- Busy stall and store: `d_we`=1, `d_wdata`=0x00A5, `mem_busy` high for 4 cycles -> no strobe while busy, a single `mem_wr` on the first non-busy cycle, `mem_wdata`=0x00A5, then `d_ack`.
- Reset mid-fetch: assert `rst`=0 in F_WAIT0, release, then pulse `mem_ready` -> no ack, outputs at reset values, and the next request is served normally.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT`=8, `mem_ready` never asserted -> `d_ack` and `err` pulse together with `d_rdata`=0x0000, 8 cycles after entering D_WAIT.
